mat_vec_sched: RTL and testbench
================================

// Module: mat_vec_sched
// PURPOSE
//  Sequencer that computes y = A*x (ROWS x SIZE matrix by SIZE vector) on one shared
//  combinational row-by-column dot-product unit. Fetches A one row at a time from a
//  row-read port, drives the unit, waits DP_WAIT cycles for settling, then emits one
//  result word per row over a valid/ready port. Sits between RLS control and the
//  dot-product datapath (gain/update steps).
// PARAMETERS
//  WIDTH    32  word length of every element (IEEE-754 single in RLS use)
//  SIZE     4   vector length / dot-product unit lanes (power of 2)
//  ROWS     4   rows of A per job (>=1)
//  DP_WAIT  2   cycles operands are held stable before dp_y is sampled (>=1)
//  AW       2   row address width, >= clog2(ROWS)
// PORTS
//  CLK        in   1           clock, all logic on rising edge
//  RST_N      in   1           synchronous reset, active low
//  start      in   1           job request; accepted only in IDLE
//  abort      in   1           cancel job, return to IDLE
//  vec_in     in   WIDTH*SIZE  x, sampled on accepted start
//  busy       out  1           high in every state except IDLE
//  done       out  1           one-cycle pulse after last result accepted
//  row_req    out  1           one-cycle row read request
//  row_addr   out  AW          row index for row_req, held until row_valid
//  row_valid  in   1           row_data valid (any latency >=1 cycle)
//  row_data   in   WIDTH*SIZE  row of A, element 0 in LSBs
//  dp_a       out  WIDTH*SIZE  dot-product operand A (registered row)
//  dp_b       out  WIDTH*SIZE  dot-product operand B (registered x)
//  dp_y       in   WIDTH       dot-product result
//  res_valid  out  1           res_data/res_idx valid
//  res_ready  in   1           consumer accepts when res_valid & res_ready
//  res_data   out  WIDTH       y[res_idx]
//  res_idx    out  AW          row index of res_data
// BEHAVIOUR
//  - Reset (RST_N=0 at edge): state IDLE; all outputs, row_idx, cnt, vec/row regs = 0.
//  - IDLE: start=1 -> vec_q<=vec_in, row_idx<=0, go FETCH. start ignored in all other states.
//  - FETCH: row_req=1 for exactly this cycle, row_addr=row_idx -> WAIT_ROW.
//  - WAIT_ROW: row_valid=1 -> row_q<=row_data, cnt<=DP_WAIT-1 -> SETTLE; else stay.
//    row_valid outside WAIT_ROW is ignored.
//  - SETTLE: dp_a=row_q, dp_b=vec_q stable; cnt==0 -> res_data<=dp_y, res_idx<=row_idx,
//    res_valid<=1 -> OUT; else cnt--.
//  - OUT: res_valid, res_data, res_idx held until res_ready=1. On accept: res_valid<=0;
//    row_idx==ROWS-1 -> DONE, else row_idx++ -> FETCH.
//  - DONE: done=1 for this single cycle -> IDLE.
//  - Latency per row (zero memory latency, res_ready=1): FETCH 1 + WAIT_ROW 1 + DP_WAIT + OUT 1.
//  - abort=1 in any state: next state IDLE, res_valid<=0, row_req<=0, no done pulse;
//    abort has priority over start and over res_ready accept in the same cycle.
//  - res_ready while res_valid=0 has no effect. dp_a/dp_b keep last values in IDLE.
//  - row_idx wraps never: terminal compare at ROWS-1; ROWS=1 gives one FETCH..OUT pass.
//  - No arithmetic in this block; widths pass through unchanged.
// STRUCTURE
//  - Shared package: state encoding (IDLE, FETCH, WAIT_ROW, SETTLE, OUT, DONE) as
//    localparams; DP_WAIT counter width constant.
//  - Single module, no sub-modules; dot-product unit instantiated by parent, wired to
//    dp_a/dp_b/dp_y. Optional sub-module mvs_settle_cnt (DP_WAIT down-counter).
// TESTING (bench models row memory with programmable latency and dp_y = dot(dp_a,dp_b)
//  after DP_WAIT-1 cycles; values IEEE-754: 1.0=3F800000, 2.0=40000000)
//  1. A=identity, x=[1,2,3,4], res_ready=1 -> results idx0..3 = 1,2,3,4; one done pulse.
//  2. Row latency 5 cycles, A rows all 1.0, x all 2.0 -> each result 8.0 (41000000);
//     row_req exactly one cycle per row, row_addr held until row_valid.
//  3. res_ready low 10 cycles on row 1 -> res_valid/data/idx stable, no row_req issued,
//     resumes on ready; 4 results total, order 0..3.
//  4. abort during SETTLE of row 2 -> busy=0 next cycle, res_valid=0, no done; new start
//     then completes full job correctly.
//  5. start pulsed while busy and spurious row_valid in IDLE -> ignored, vec_q unchanged.
//  6. RST_N low mid-job for 1 cycle -> all outputs 0, state IDLE next cycle.

Source files
------------

// File: rtl/mat_vec_sched_pkg.sv
// Shared constants for the mat_vec_sched row sequencer: FSM state encoding and
// the width of the settle down-counter.
package mat_vec_sched_pkg;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_FETCH    = 3'd1;
    localparam logic [2:0] ST_WAIT_ROW = 3'd2;
    localparam logic [2:0] ST_SETTLE   = 3'd3;
    localparam logic [2:0] ST_OUT      = 3'd4;
    localparam logic [2:0] ST_DONE     = 3'd5;

    // Settle counter width; DP_WAIT must not exceed 2**CNT_W.
    localparam int CNT_W = 8;

endpackage

// File: rtl/mat_vec_sched.sv
// Sequencer for y = A*x on one shared combinational dot-product unit: fetches one
// row of A per pass, holds operands DP_WAIT cycles, then hands out one result per row.
module mat_vec_sched
    import mat_vec_sched_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SIZE    = 4,
    parameter int ROWS    = 4,
    parameter int DP_WAIT = 2,
    parameter int AW      = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    input  logic                  start,
    input  logic                  abort,
    input  logic [WIDTH*SIZE-1:0] vec_in,
    output logic                  busy,
    output logic                  done,
    output logic                  row_req,
    output logic [AW-1:0]         row_addr,
    input  logic                  row_valid,
    input  logic [WIDTH*SIZE-1:0] row_data,
    output logic [WIDTH*SIZE-1:0] dp_a,
    output logic [WIDTH*SIZE-1:0] dp_b,
    input  logic [WIDTH-1:0]      dp_y,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_data,
    output logic [AW-1:0]         res_idx
);

    logic [2:0]            state_reg;
    logic [2:0]            state_next;
    logic [AW-1:0]         row_idx_reg;
    logic [CNT_W-1:0]      cnt_reg;
    logic [WIDTH*SIZE-1:0] vec_reg;
    logic [WIDTH*SIZE-1:0] row_reg;
    logic                  res_valid_reg;
    logic [WIDTH-1:0]      res_data_reg;
    logic [AW-1:0]         res_idx_reg;
    logic                  last_row;

    assign last_row = (row_idx_reg == AW'(ROWS - 1));

    // abort wins over every other transition, including a same-cycle accept
    always_comb begin
        state_next = state_reg;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state_reg)
                ST_IDLE:     if (start) state_next = ST_FETCH;
                ST_FETCH:    state_next = ST_WAIT_ROW;
                ST_WAIT_ROW: if (row_valid) state_next = ST_SETTLE;
                ST_SETTLE:   if (cnt_reg == '0) state_next = ST_OUT;
                ST_OUT:      if (res_ready) state_next = last_row ? ST_DONE : ST_FETCH;
                ST_DONE:     state_next = ST_IDLE;
                default:     state_next = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_reg     <= ST_IDLE;
            row_idx_reg   <= '0;
            cnt_reg       <= '0;
            vec_reg       <= '0;
            row_reg       <= '0;
            res_valid_reg <= 1'b0;
            res_data_reg  <= '0;
            res_idx_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (abort) begin
                res_valid_reg <= 1'b0;
            end else begin
                case (state_reg)
                    ST_IDLE: begin
                        if (start) begin
                            vec_reg     <= vec_in;
                            row_idx_reg <= '0;
                        end
                    end
                    ST_WAIT_ROW: begin
                        if (row_valid) begin
                            row_reg <= row_data;
                            cnt_reg <= CNT_W'(DP_WAIT - 1);
                        end
                    end
                    ST_SETTLE: begin
                        if (cnt_reg == '0) begin
                            res_data_reg  <= dp_y;
                            res_idx_reg   <= row_idx_reg;
                            res_valid_reg <= 1'b1;
                        end else begin
                            cnt_reg <= cnt_reg - CNT_W'(1);
                        end
                    end
                    ST_OUT: begin
                        if (res_ready) begin
                            res_valid_reg <= 1'b0;
                            if (!last_row) row_idx_reg <= row_idx_reg + AW'(1);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // row_idx only moves after a result is accepted, so it doubles as the held address
    assign busy      = (state_reg != ST_IDLE);
    assign done      = (state_reg == ST_DONE);
    assign row_req   = (state_reg == ST_FETCH);
    assign row_addr  = row_idx_reg;
    assign dp_a      = row_reg;
    assign dp_b      = vec_reg;
    assign res_valid = res_valid_reg;
    assign res_data  = res_data_reg;
    assign res_idx   = res_idx_reg;

endmodule

// File: tb/tb_mat_vec_sched.sv
// Directed bench for mat_vec_sched: row memory with programmable latency and a
// delayed IEEE-754 dot-product model; expected results are hand-computed constants.
module tb_mat_vec_sched;

    localparam logic [31:0] F0  = 32'h0000_0000;
    localparam logic [31:0] F1  = 32'h3F80_0000;
    localparam logic [31:0] F2  = 32'h4000_0000;
    localparam logic [31:0] F3  = 32'h4040_0000;
    localparam logic [31:0] F4  = 32'h4080_0000;
    localparam logic [31:0] F6  = 32'h40C0_0000;
    localparam logic [31:0] F8  = 32'h4100_0000;
    localparam logic [31:0] F10 = 32'h4120_0000;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [127:0] vec_in = '0;
    logic         busy, done, row_req;
    logic [1:0]   row_addr;
    logic         row_valid;
    logic [127:0] row_data;
    logic [127:0] dp_a, dp_b;
    logic [31:0]  dp_y = '0;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [31:0]  res_data;
    logic [1:0]   res_idx;

    logic         mem_valid = 1'b0;
    logic [127:0] mem_data = '0;
    logic         spur_valid = 1'b0;
    logic [127:0] spur_data = '0;
    logic [127:0] mem [4];
    int           mem_lat = 1;
    int           mem_cnt = 0;
    logic [1:0]   mem_addr = '0;
    logic [31:0]  dp_dly = '0;

    int           n_cmp = 0;
    int           n_bad = 0;
    int           done_cnt = 0, req_cnt = 0, req_long = 0, addr_err = 0;
    logic         req_prev = 1'b0;
    logic [31:0]  q_data [$];
    logic [1:0]   q_idx [$];

    assign row_valid = mem_valid | spur_valid;
    assign row_data  = spur_valid ? spur_data : mem_data;

    mat_vec_sched #(.WIDTH(32), .SIZE(4), .ROWS(4), .DP_WAIT(2), .AW(2)) dut (
        .CLK(CLK), .RST_N(RST_N), .start(start), .abort(abort), .vec_in(vec_in),
        .busy(busy), .done(done), .row_req(row_req), .row_addr(row_addr),
        .row_valid(row_valid), .row_data(row_data), .dp_a(dp_a), .dp_b(dp_b),
        .dp_y(dp_y), .res_valid(res_valid), .res_ready(res_ready),
        .res_data(res_data), .res_idx(res_idx)
    );

    always #5 CLK = ~CLK;

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] dot(input logic [127:0] a, input logic [127:0] b);
        real acc;
        acc = 0.0;
        for (int i = 0; i < 4; i++) acc += f2r(a[i*32 +: 32]) * f2r(b[i*32 +: 32]);
        return r2f(acc);
    endfunction

    // dot-product unit answers DP_WAIT-1 = 1 cycle after its operands change
    always @(negedge CLK) begin
        dp_y   = dp_dly;
        dp_dly = dot(dp_a, dp_b);
    end

    // row memory: row_valid pulses mem_lat cycles after the row_req cycle
    always @(negedge CLK) begin
        mem_valid = 1'b0;
        if (!RST_N) begin
            mem_cnt = 0;
        end else begin
            if (mem_cnt > 0) begin
                if (row_addr !== mem_addr) addr_err++;
                mem_cnt--;
                if (mem_cnt == 0) begin
                    mem_valid = 1'b1;
                    mem_data  = mem[mem_addr];
                end
            end
            if (row_req) begin
                mem_cnt  = mem_lat;
                mem_addr = row_addr;
            end
        end
    end

    always @(negedge CLK) begin
        if (RST_N) begin
            if (res_valid && res_ready && !abort) begin
                q_data.push_back(res_data);
                q_idx.push_back(res_idx);
                $display("result idx=%0d data=%h t=%0t", res_idx, res_data, $time);
            end
            if (done) done_cnt++;
            if (row_req) begin
                req_cnt++;
                if (req_prev) req_long++;
            end
        end
        req_prev = row_req;
    end

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic clear_obs();
        q_data.delete();
        q_idx.delete();
        done_cnt = 0;
        req_cnt  = 0;
        req_long = 0;
        addr_err = 0;
    endtask

    task automatic pulse_start(input logic [127:0] v);
        vec_in = v;
        start  = 1'b1;
        tick();
        start  = 1'b0;
    endtask

    // counts negedges from the start-accept edge up to and including the done cycle
    task automatic wait_done(input string tag, output int cycles);
        cycles = 0;
        for (int i = 0; i < 400; i++) begin
            @(negedge CLK);
            cycles++;
            if (done) break;
        end
        check({tag, "_done_seen"}, done, 1);
        tick();
    endtask

    task automatic check_job(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                             input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] e [4];
        e = '{e0, e1, e2, e3};
        check({tag, "_nres"}, q_data.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < q_data.size()) begin
                check($sformatf("%s_idx%0d", tag, i), q_idx[i], i);
                check($sformatf("%s_data%0d", tag, i), q_data[i], e[i]);
            end
        end
    endtask

    task automatic load_identity();
        mem[0] = {F0, F0, F0, F1};
        mem[1] = {F0, F0, F1, F0};
        mem[2] = {F0, F1, F0, F0};
        mem[3] = {F1, F0, F0, F0};
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int cyc;
        logic [127:0] x1234;
        logic [31:0]  s_data;
        logic [1:0]   s_idx;
        logic         stable;
        int           req0;
        x1234 = {F4, F3, F2, F1};

        tick(3);
        RST_N = 1'b1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_row_req", row_req, 0);
        check("rst_row_addr", row_addr, 0);
        check("rst_dp_a", dp_a, 0);
        check("rst_dp_b", dp_b, 0);
        check("rst_res_valid", res_valid, 0);
        check("rst_res_data", res_data, 0);
        check("rst_res_idx", res_idx, 0);

        // 1: identity matrix, unit latency, always ready
        load_identity();
        mem_lat = 1;
        clear_obs();
        pulse_start(x1234);
        check("t1_busy", busy, 1);
        check("t1_row_req", row_req, 1);
        wait_done("t1", cyc);
        check("t1_cycles", cyc, 21);
        check_job("t1", F1, F2, F3, F4);
        check("t1_done_cnt", done_cnt, 1);
        check("t1_idle", busy, 0);

        // 2: five-cycle row latency, all-ones A times all-twos x
        for (int r = 0; r < 4; r++) mem[r] = {F1, F1, F1, F1};
        mem_lat = 5;
        clear_obs();
        pulse_start({F2, F2, F2, F2});
        wait_done("t2", cyc);
        check("t2_cycles", cyc, 37);
        check_job("t2", F8, F8, F8, F8);
        check("t2_req_cnt", req_cnt, 4);
        check("t2_req_long", req_long, 0);
        check("t2_addr_hold", addr_err, 0);

        // 3: consumer stalls on row 1 for 10 cycles
        load_identity();
        mem_lat = 1;
        clear_obs();
        pulse_start(x1234);
        for (int i = 0; i < 100; i++) begin
            if (res_valid && res_idx == 2'd1) break;
            tick();
        end
        check("t3_reach_valid", res_valid, 1);
        res_ready = 1'b0;
        s_data = res_data;
        s_idx  = res_idx;
        req0   = req_cnt;
        stable = 1'b1;
        repeat (10) begin
            tick();
            if (res_valid !== 1'b1 || res_data !== s_data || res_idx !== s_idx) stable = 1'b0;
        end
        check("t3_stall_data", s_data, F2);
        check("t3_stall_idx", s_idx, 1);
        check("t3_stable", stable, 1);
        check("t3_no_req", req_cnt - req0, 0);
        res_ready = 1'b1;
        wait_done("t3", cyc);
        check_job("t3", F1, F2, F3, F4);
        check("t3_done_cnt", done_cnt, 1);

        // 4: abort in SETTLE of row 2, then a clean job on a lower-triangular A
        mem[0] = {F0, F0, F0, F1};
        mem[1] = {F0, F0, F1, F1};
        mem[2] = {F0, F1, F1, F1};
        mem[3] = {F1, F1, F1, F1};
        clear_obs();
        pulse_start(x1234);
        for (int i = 0; i < 100; i++) begin
            if (dp_a == mem[2] && busy && !res_valid) break;
            tick();
        end
        check("t4_reach_settle", dp_a, mem[2]);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check("t4_abort_busy", busy, 0);
        check("t4_abort_valid", res_valid, 0);
        check("t4_abort_req", row_req, 0);
        tick(3);
        check("t4_no_done", done_cnt, 0);
        check("t4_partial_n", q_data.size(), 2);
        clear_obs();
        pulse_start(x1234);
        wait_done("t4b", cyc);
        check_job("t4b", F1, F3, F6, F10);
        check("t4b_done_cnt", done_cnt, 1);

        // 5: start while busy is ignored; spurious row_valid in IDLE is ignored
        load_identity();
        clear_obs();
        pulse_start(x1234);
        tick(3);
        vec_in = {F2, F2, F2, F2};
        start  = 1'b1;
        tick();
        start  = 1'b0;
        wait_done("t5", cyc);
        check_job("t5", F1, F2, F3, F4);
        check("t5_done_cnt", done_cnt, 1);
        spur_data  = {F4, F4, F4, F4};
        spur_valid = 1'b1;
        tick(2);
        spur_valid = 1'b0;
        tick();
        check("t5_spur_busy", busy, 0);
        check("t5_spur_dp_a", dp_a, mem[3]);
        check("t5_spur_dp_b", dp_b, x1234);
        check("t5_spur_req", row_req, 0);

        // 6: one-cycle reset in the middle of a job
        clear_obs();
        pulse_start(x1234);
        tick(7);
        RST_N = 1'b0;
        tick();
        RST_N = 1'b1;
        check("t6_busy", busy, 0);
        check("t6_done", done, 0);
        check("t6_row_req", row_req, 0);
        check("t6_row_addr", row_addr, 0);
        check("t6_dp_a", dp_a, 0);
        check("t6_dp_b", dp_b, 0);
        check("t6_res_valid", res_valid, 0);
        check("t6_res_data", res_data, 0);
        check("t6_res_idx", res_idx, 0);
        tick();
        check("t6_stay_idle", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
